// File: rtl/fetch_buffer.sv
// fetch_buffer: dual-wide in-order instruction queue between fetch and decode.
// Ports: clk, rst_n (async, active-low), flush; in_valid/in_inst_a/b/in_pc_a/b
//   fetch bundle in, in_ready/stall_pc backpressure; out_valid_a/b,
//   out_inst_a/b, out_pc_a/b head and head+1 view; out_take consumed count;
//   count occupancy. Macro FETCH_BUF_STATS_EN adds stat_stall_cycles and
//   stat_bubbles saturating counters.
module fetch_buffer #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_inst_a,
    input  logic [XLEN-1:0]            in_inst_b,
    input  logic [XLEN-1:0]            in_pc_a,
    input  logic [XLEN-1:0]            in_pc_b,
    output logic                       in_ready,
    output logic                       stall_pc,
    output logic                       out_valid_a,
    output logic                       out_valid_b,
    output logic [XLEN-1:0]            out_inst_a,
    output logic [XLEN-1:0]            out_inst_b,
    output logic [XLEN-1:0]            out_pc_a,
    output logic [XLEN-1:0]            out_pc_b,
    input  logic [1:0]                 out_take,
    output logic [$clog2(DEPTH):0]     count
`ifdef FETCH_BUF_STATS_EN
    ,
    output logic [31:0]                stat_stall_cycles,
    output logic [31:0]                stat_bubbles
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] inst_q [DEPTH];
    logic [XLEN-1:0] inst_d [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [XLEN-1:0] pc_d   [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [PW-1:0]   head1;
    logic [PW-1:0]   wr_b_idx;
    logic            a_ok, b_ok, enq;
    logic [1:0]      take;
    logic [CW-1:0]   nenq, ndeq;

    always_comb begin
        // Credit only the registered occupancy; same-cycle dequeues don't count.
        in_ready    = (count_q <= CW'(DEPTH - 2));
        stall_pc    = ~in_ready;
        head1       = head_q + PW'(1);
        out_valid_a = (count_q != '0);
        out_valid_b = (count_q >= CW'(2));
        out_inst_a  = out_valid_a ? inst_q[head_q] : '0;
        out_pc_a    = out_valid_a ? pc_q[head_q]   : '0;
        out_inst_b  = out_valid_b ? inst_q[head1]  : '0;
        out_pc_b    = out_valid_b ? pc_q[head1]    : '0;
        count       = count_q;

        // All-zero slots are fetch bubbles and are dropped; survivors compact.
        a_ok     = |in_inst_a;
        b_ok     = |in_inst_b;
        enq      = in_valid & in_ready & ~flush;
        nenq     = enq ? (CW'(a_ok) + CW'(b_ok)) : '0;
        wr_b_idx = tail_q + PW'(a_ok);

        take = (out_take == 2'd3) ? 2'd2 : out_take;
        ndeq = (CW'(take) > count_q) ? count_q : CW'(take);

        for (int i = 0; i < DEPTH; i++) begin
            inst_d[i] = inst_q[i];
            pc_d[i]   = pc_q[i];
        end
        if (enq && a_ok) begin
            inst_d[tail_q] = in_inst_a;
            pc_d[tail_q]   = in_pc_a;
        end
        if (enq && b_ok) begin
            inst_d[wr_b_idx] = in_inst_b;
            pc_d[wr_b_idx]   = in_pc_b;
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + ndeq[PW-1:0];
            tail_d  = tail_q + nenq[PW-1:0];
            count_d = count_q + nenq - ndeq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= inst_d[i];
                pc_q[i]   <= pc_d[i];
            end
        end
    end

`ifdef FETCH_BUF_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bub_cnt_q, bub_cnt_d;
    logic [1:0]  nbub;
    logic [32:0] bub_sum;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        nbub      = enq ? (2'(~a_ok) + 2'(~b_ok)) : 2'd0;
        bub_sum   = {1'b0, bub_cnt_q} + 33'(nbub);
        bub_cnt_d = bub_sum[32] ? 32'hFFFF_FFFF : bub_sum[31:0];
        stat_stall_cycles = stall_cnt_q;
        stat_bubbles      = bub_cnt_q;
    end

    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            bub_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            bub_cnt_q   <= bub_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed and randomized check of fetch_buffer against a
// queue-based model of the bundle/bubble/clamp/flush rules.
module tb_fetch_buffer;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic [XLEN-1:0] in_inst_a, in_inst_b, in_pc_a, in_pc_b;
    logic            in_ready, stall_pc;
    logic            out_valid_a, out_valid_b;
    logic [XLEN-1:0] out_inst_a, out_inst_b, out_pc_a, out_pc_b;
    logic [1:0]      out_take;
    logic [3:0]      count;
`ifdef FETCH_BUF_STATS_EN
    logic [31:0]     stat_stall_cycles, stat_bubbles;
    int unsigned     m_stall, m_bub;
`endif

    fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_inst_a(in_inst_a), .in_inst_b(in_inst_b),
        .in_pc_a(in_pc_a), .in_pc_b(in_pc_b),
        .in_ready(in_ready), .stall_pc(stall_pc),
        .out_valid_a(out_valid_a), .out_valid_b(out_valid_b),
        .out_inst_a(out_inst_a), .out_inst_b(out_inst_b),
        .out_pc_a(out_pc_a), .out_pc_b(out_pc_b),
        .out_take(out_take), .count(count)
`ifdef FETCH_BUF_STATS_EN
        , .stat_stall_cycles(stat_stall_cycles), .stat_bubbles(stat_bubbles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".count"}, 64'(count), 64'd0);
        check({tag, ".valid_a"}, 64'(out_valid_a), 64'd0);
        check({tag, ".valid_b"}, 64'(out_valid_b), 64'd0);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        check({tag, ".stall_pc"}, 64'(stall_pc), 64'd0);
        check({tag, ".data"},
              64'(out_inst_a | out_inst_b | out_pc_a | out_pc_b), 64'd0);
    endtask

    // Called at negedge: drive, compare against model, advance one clock.
    task automatic step(input logic fl, input logic v,
                        input logic [31:0] a, input logic [31:0] pa,
                        input logic [31:0] b, input logic [31:0] pb,
                        input logic [1:0] tk);
        int n, nd, tkc;
        bit rdy;
        logic [31:0] ia, pca, ib, pcb;
        flush = fl; in_valid = v; out_take = tk;
        in_inst_a = a; in_pc_a = pa; in_inst_b = b; in_pc_b = pb;
        #1;
        n = q.size();
        rdy = (DEPTH - n) >= 2;
        ia = 0; pca = 0; ib = 0; pcb = 0;
        if (n >= 1) begin ia = q[0].inst; pca = q[0].pc; end
        if (n >= 2) begin ib = q[1].inst; pcb = q[1].pc; end
        check("count", 64'(count), 64'(n));
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("stall_pc", 64'(stall_pc), 64'(!rdy));
        check("valid_a", 64'(out_valid_a), 64'(n >= 1));
        check("valid_b", 64'(out_valid_b), 64'(n >= 2));
        check("inst_a", 64'(out_inst_a), 64'(ia));
        check("pc_a", 64'(out_pc_a), 64'(pca));
        check("inst_b", 64'(out_inst_b), 64'(ib));
        check("pc_b", 64'(out_pc_b), 64'(pcb));
`ifdef FETCH_BUF_STATS_EN
        check("stat_stall", 64'(stat_stall_cycles), 64'(m_stall));
        check("stat_bub", 64'(stat_bubbles), 64'(m_bub));
        if (v && !rdy) m_stall++;
        if (v && rdy && !fl) m_bub += int'(a == 0) + int'(b == 0);
`endif
        if (fl) begin
            q.delete();
        end else begin
            tkc = (tk == 2'd3) ? 2 : int'(tk);
            nd = (tkc < n) ? tkc : n;
            repeat (nd) void'(q.pop_front());
            if (v && rdy) begin
                if (a != 0) q.push_back('{inst: a, pc: pa});
                if (b != 0) q.push_back('{inst: b, pc: pb});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 0, 0, 0, 2'd0);
    endtask

    task automatic bundle(input logic [31:0] pa, input logic [1:0] tk);
        step(1'b0, 1'b1, $urandom | 32'h1, pa, $urandom | 32'h1, pa + 4, tk);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs(tag);
        q.delete();
`ifdef FETCH_BUF_STATS_EN
        m_stall = 0; m_bub = 0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] ra, rb;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_take = 2'd0;
        in_inst_a = 0; in_inst_b = 0; in_pc_a = 0; in_pc_b = 0;
`ifdef FETCH_BUF_STATS_EN
        m_stall = 0; m_bub = 0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_idle_outputs("reset");

        step(1'b0, 1'b1, 32'h00500093, 0, 32'h00100113, 4, 2'd0);
        check("single.count", 64'(count), 64'd2);
        check("single.pc_a", 64'(out_pc_a), 64'd0);
        check("single.pc_b", 64'(out_pc_b), 64'd4);
        check("single.valid_b", 64'(out_valid_b), 64'd1);

        for (int i = 1; i < 4; i++) bundle(32'(8 * i), 2'd0);
        check("full.count", 64'(count), 64'd8);
        check("full.in_ready", 64'(in_ready), 64'd0);
        check("full.stall_pc", 64'(stall_pc), 64'd1);
        repeat (3) step(1'b0, 1'b1, 32'h11, 32, 32'h22, 36, 2'd0);
        check("held.count", 64'(count), 64'd8);

        idle();
        step(1'b0, 1'b0, 0, 0, 0, 0, 2'd2);
        check("drain.count", 64'(count), 64'd6);
        check("drain.in_ready", 64'(in_ready), 64'd1);
        bundle(32, 2'd2);
        check("wrap.count", 64'(count), 64'd6);
        check("wrap.pc_a", 64'(out_pc_a), 64'd16);
        repeat (4) step(1'b0, 1'b0, 0, 0, 0, 0, 2'd3);
        check("wrap.empty", 64'(count), 64'd0);

        step(1'b0, 1'b1, 0, 4, 32'h00208233, 8, 2'd0);
        check("bubble.count", 64'(count), 64'd1);
        check("bubble.pc_a", 64'(out_pc_a), 64'd8);
        check("bubble.valid_b", 64'(out_valid_b), 64'd0);
        step(1'b0, 1'b0, 0, 0, 0, 0, 2'd2);
        check("clamp.count", 64'(count), 64'd0);
        idle();

        bundle(64, 2'd0);
        bundle(72, 2'd0);
        step(1'b0, 1'b1, 32'h0, 80, 32'h33, 84, 2'd0);
        check("preflush.count", 64'(count), 64'd5);
        step(1'b1, 1'b1, 32'h44, 88, 32'h55, 92, 2'd1);
        check_idle_outputs("flush");
        idle();

        bundle(96, 2'd0);
        bundle(104, 2'd1);
        async_reset("midreset");
        idle();

        pc = 32'h1000;
        for (int i = 0; i < 600; i++) begin
            ra = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom | 32'h1);
            rb = ($urandom_range(0, 5) == 0) ? 32'h0 : ($urandom | 32'h1);
            step($urandom_range(0, 40) == 0, $urandom_range(0, 9) < 7,
                 ra, pc, rb, pc + 4, 2'($urandom_range(0, 3)));
            if (in_valid && !flush && q.size() != 0) pc = pc + 8;
        end
        repeat (6) step(1'b0, 1'b0, 0, 0, 0, 0, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
